// File: rtl/alu_issue_seq.sv
// Issue/capture sequencer for the 12-bit ALU: one op in flight, enable held S=max(SETTLE_CYCLES,1) cycles, oVALID after edge S;
// oREADY stays low from acceptance until oVALID is acked. Optional capture counter oOP_CNT when ALU_OPCOUNT_EN is defined.
module alu_issue_seq #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4,
  parameter logic [3:0]  SUB_CODE      = 4'd1
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iREQ,
  output logic        oREADY,
  input  logic [3:0]  iCTRL,
  input  logic [11:0] iOP1,
  input  logic [11:0] iOP2,
  output logic        oALU_EN,
  output logic [3:0]  oALU_CTRL,
  output logic [11:0] oALU_OP1,
  output logic [11:0] oALU_OP2,
  input  logic [11:0] iALU_RES,
  input  logic        iALU_NEG,
  input  logic        iALU_ALL_ZEROn,
  input  logic        iALU_ANY_POS,
  output logic        oVALID,
  input  logic        iACK,
`ifdef ALU_OPCOUNT_EN
  output logic [11:0] oOP_CNT,
`endif
  output logic [11:0] oRES,
  output logic        oFLAG_N,
  output logic        oFLAG_Z,
  output logic        oFLAG_P
);

  // A zero settle time still needs one enabled cycle before the result is sampled.
  localparam int unsigned     SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (iREQ) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (iACK) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign oREADY  = (state == IDLE);
  assign oALU_EN = (state == EXEC);
  assign oVALID  = (state == DONE);

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      cnt       <= '0;
      oALU_CTRL <= '0;
      oALU_OP1  <= '0;
      oALU_OP2  <= '0;
      oRES      <= '0;
      oFLAG_N   <= 1'b0;
      oFLAG_Z   <= 1'b0;
      oFLAG_P   <= 1'b0;
    end else begin
      if (accept) begin
        oALU_CTRL <= iCTRL;
        oALU_OP1  <= iOP1;
        oALU_OP2  <= iOP2;
        cnt       <= CNT_LOAD;
      end
      if (capture) begin
        oRES <= iALU_RES;
        // Only subtract/compare defines the condition flags; other ops leave them sticky.
        if (oALU_CTRL == SUB_CODE) begin
          oFLAG_N <= iALU_NEG;
          oFLAG_Z <= ~iALU_ALL_ZEROn;
          oFLAG_P <= iALU_ANY_POS;
        end
      end else if (state == EXEC) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef ALU_OPCOUNT_EN
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oOP_CNT <= '0;
    end else if (capture) begin
      oOP_CNT <= oOP_CNT + 12'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: behavioural ALU, expected results queued at issue and compared when oVALID rises.
module tb_alu_issue_seq;

  typedef struct packed {
    logic [11:0] res;
    logic        n;
    logic        z;
    logic        p;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req0, ack, ack0;
  logic [3:0]  ctrl;
  logic [11:0] op1, op2;

  logic        ready, alu_en, valid;
  logic [3:0]  alu_ctrl;
  logic [11:0] alu_op1, alu_op2, alu_res, res;
  logic        alu_neg, alu_zn, alu_pos, flag_n, flag_z, flag_p;

  logic        ready0, alu_en0, valid0;
  logic [3:0]  alu_ctrl0;
  logic [11:0] alu_op10, alu_op20, alu_res0, res0;
  logic        alu_neg0, alu_zn0, alu_pos0, flag_n0, flag_z0, flag_p0;
`ifdef ALU_OPCOUNT_EN
  logic [11:0] op_cnt, op_cnt0;
`endif

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_main   = 0;
  int   n0       = 0;
  logic prev_vld = 1'b0;
  logic prev_vld0 = 1'b0;
  logic mf_n = 1'b0, mf_z = 1'b0, mf_p = 1'b0;
  exp_t sb[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  function automatic logic [11:0] alu_f(input logic [3:0] c, input logic [11:0] a, input logic [11:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return a & b;
    endcase
  endfunction

  assign alu_res  = alu_f(alu_ctrl, alu_op1, alu_op2);
  assign alu_neg  = alu_res[11];
  assign alu_zn   = |alu_res;
  assign alu_pos  = !alu_res[11] && (|alu_res);
  assign alu_res0 = alu_f(alu_ctrl0, alu_op10, alu_op20);
  assign alu_neg0 = alu_res0[11];
  assign alu_zn0  = |alu_res0;
  assign alu_pos0 = !alu_res0[11] && (|alu_res0);

  alu_issue_seq u_dut (
    .iCLK(clk), .iRSTn(rst_n), .iREQ(req), .oREADY(ready),
    .iCTRL(ctrl), .iOP1(op1), .iOP2(op2),
    .oALU_EN(alu_en), .oALU_CTRL(alu_ctrl), .oALU_OP1(alu_op1), .oALU_OP2(alu_op2),
    .iALU_RES(alu_res), .iALU_NEG(alu_neg), .iALU_ALL_ZEROn(alu_zn), .iALU_ANY_POS(alu_pos),
    .oVALID(valid), .iACK(ack),
`ifdef ALU_OPCOUNT_EN
    .oOP_CNT(op_cnt),
`endif
    .oRES(res), .oFLAG_N(flag_n), .oFLAG_Z(flag_z), .oFLAG_P(flag_p)
  );

  alu_issue_seq #(.SETTLE_CYCLES(0)) u_dut0 (
    .iCLK(clk), .iRSTn(rst_n), .iREQ(req0), .oREADY(ready0),
    .iCTRL(ctrl), .iOP1(op1), .iOP2(op2),
    .oALU_EN(alu_en0), .oALU_CTRL(alu_ctrl0), .oALU_OP1(alu_op10), .oALU_OP2(alu_op20),
    .iALU_RES(alu_res0), .iALU_NEG(alu_neg0), .iALU_ALL_ZEROn(alu_zn0), .iALU_ANY_POS(alu_pos0),
    .oVALID(valid0), .iACK(ack0),
`ifdef ALU_OPCOUNT_EN
    .oOP_CNT(op_cnt0),
`endif
    .oRES(res0), .oFLAG_N(flag_n0), .oFLAG_Z(flag_z0), .oFLAG_P(flag_p0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void sb_push(input logic [3:0] c, input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    r = alu_f(c, a, b);
    if (c == 4'd1) begin
      mf_n = r[11];
      mf_z = (r == 12'd0);
      mf_p = !r[11] && (r != 12'd0);
    end
    sb.push_back('{res: r, n: mf_n, z: mf_z, p: mf_p});
  endfunction

  task automatic issue(input logic [3:0] c, input logic [11:0] a, input logic [11:0] b);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    req = 1'b1; ctrl = c; op1 = a; op2 = b;
    sb_push(c, a, b);
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!valid) check("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic ack_done();
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
      n_main   = 0;
    end else begin
      if (valid && !prev_vld) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e_mon = sb.pop_front();
          check("res", 32'(res), 32'(e_mon.res));
          check("flag_n", 32'(flag_n), 32'(e_mon.n));
          check("flag_z", 32'(flag_z), 32'(e_mon.z));
          check("flag_p", 32'(flag_p), 32'(e_mon.p));
        end
        n_main++;
      end
      prev_vld = valid;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld0 = 1'b0;
      n0        = 0;
    end else begin
      if (valid0 && !prev_vld0) n0++;
      prev_vld0 = valid0;
    end
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; req0 = 1'b0; ack = 1'b0; ack0 = 1'b0;
    ctrl = 4'd0; op1 = 12'd0; op2 = 12'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_en", 32'(alu_en), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_alu_op", {alu_ctrl, alu_op1, alu_op2}, 32'd0);
    check("rst_flags", {flag_n, flag_z, flag_p}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD with S=4: enable exactly four cycles, valid after edge 4
    issue(4'd0, 12'o0001, 12'o0002);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("add_en", 32'(alu_en), 32'd1);
      check("add_valid_early", 32'(valid), 32'd0);
    end
    @(negedge clk);
    check("add_valid", 32'(valid), 32'd1);
    check("add_en_off", 32'(alu_en), 32'd0);
    check("add_ready", 32'(ready), 32'd0);
    ack_done();
    @(negedge clk);
    check("ack_ready", 32'(ready), 32'd1);
    check("ack_valid", 32'(valid), 32'd0);
    check("res_hold", 32'(res), 32'o0003);

    // flag updates: SUB sets, non-SUB holds
    issue(4'd1, 12'o0005, 12'o0005); wait_valid(); ack_done();
    issue(4'd0, 12'o0003, 12'o0004); wait_valid(); ack_done();
    issue(4'd1, 12'o0002, 12'o0005); wait_valid(); ack_done();
    issue(4'd1, 12'o0005, 12'o0002); wait_valid(); ack_done();

    // backpressure with a stray request pulse
    issue(4'd0, 12'o1234, 12'o0007);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin req = 1'b1; op1 = 12'o7777; end
      if (i == 4) req = 1'b0;
      @(negedge clk);
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_ready", 32'(ready), 32'd0);
      check("bp_res", 32'(res), 32'o1243);
      check("bp_op1", 32'(alu_op1), 32'o1234);
    end
    ack_done();

    // ack with request already pending: IDLE lasts exactly one cycle
    issue(4'd2, 12'o7070, 12'o0770);
    wait_valid();
    ack = 1'b1; req = 1'b1; ctrl = 4'd0; op1 = 12'o0010; op2 = 12'o0020;
    sb_push(4'd0, 12'o0010, 12'o0020);
    @(posedge clk);
    #1 ack = 1'b0;
    @(negedge clk);
    check("b2b_ready", 32'(ready), 32'd1);
    check("b2b_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("b2b_ready_lo", 32'(ready), 32'd0);
    check("b2b_en", 32'(alu_en), 32'd1);
    check("b2b_op1", 32'(alu_op1), 32'o0010);
    wait_valid();
    ack_done();

    // asynchronous reset in the second EXEC cycle drops the op
    issue(4'd0, 12'o0100, 12'o0001);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_en", 32'(alu_en), 32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_ready", 32'(ready), 32'd1);
    check("mrst_flags", {flag_n, flag_z, flag_p}, 32'd0);
    check("mrst_res", 32'(res), 32'd0);
    sb.delete();
    mf_n = 1'b0; mf_z = 1'b0; mf_p = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(4'd1, 12'o0007, 12'o0010); wait_valid(); ack_done();
    issue(4'd0, 12'o0011, 12'o0022); wait_valid(); ack_done();
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
`ifdef ALU_OPCOUNT_EN
    check("op_cnt", 32'(op_cnt), 32'(12'(n_main)));
`endif

    // SETTLE_CYCLES=0 behaves as one settle cycle
    req0 = 1'b1; ctrl = 4'd0; op1 = 12'o0007; op2 = 12'o0010;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    check("s0_en", 32'(alu_en0), 32'd1);
    check("s0_valid_early", 32'(valid0), 32'd0);
    @(negedge clk);
    check("s0_valid", 32'(valid0), 32'd1);
    check("s0_en_off", 32'(alu_en0), 32'd0);
    check("s0_res", 32'(res0), 32'o0017);
    ack0 = 1'b1;
    @(posedge clk);
    #1 ack0 = 1'b0;
`ifdef ALU_OPCOUNT_EN
    begin
      int t = 0;
      req0 = 1'b1; ack0 = 1'b1;
      while (n0 < 4097 && t < 20000) begin
        @(negedge clk);
        t++;
      end
      if (n0 < 4097) check("opcnt_timeout", 32'(n0), 32'd4097);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      ack0 = 1'b0;
      check("op_cnt_wrap", 32'(op_cnt0), 32'o0001);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
